config_write_arbiter: RTL



---
 rtl/config_arb_pkg.sv | 15 +
 rtl/config_word_fifo.sv | 55 +++++
 rtl/config_write_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/config_arb_pkg.sv
// rtl/config_arb_pkg.sv - shared encodings for the configuration write arbiter
package config_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT_UART = 2'd1,
        ST_GRANT_PAR  = 2'd2,
        ST_DRAIN      = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_UART = 2'b01;
    localparam logic [1:0] OWNER_PAR  = 2'b10;

endpackage

// File: rtl/config_word_fifo.sv
// rtl/config_word_fifo.sv - synchronous word FIFO between the granted loader and the frame writer
module config_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // The extra pointer bit separates the full case from the empty case.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/config_write_arbiter.sv
// rtl/config_write_arbiter.sv - session arbiter sharing the config word bus between UART and parallel loaders
module config_write_arbiter
    import config_arb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 16777,
    parameter int PRIO_PAR     = 0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        UartActive,
    input  logic [31:0] UartWriteData,
    input  logic        UartWriteStrobe,
    input  logic        ParActive,
    input  logic [31:0] ParWriteData,
    input  logic        ParWriteStrobe,
    input  logic        CfgReady,
    output logic [31:0] CfgWriteData,
    output logic        CfgValid,
    output logic [1:0]  Owner,
    output logic        Overflow,
    output logic        Rejected,
    output logic        TimedOut,
    output logic        SessionDone
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(IDLE_TIMEOUT);

    arb_state_t  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        mask_uart_q, mask_uart_d;
    logic        mask_par_q, mask_par_d;
    logic        overflow_q, overflow_d;
    logic        timed_out_q, timed_out_d;
    logic        rejected_q, rejected_d;
    logic        session_done_q, session_done_d;

    logic        fifo_full, fifo_empty, pop, push;
    logic [AW:0] fifo_count, fifo_count_next;
    logic        owner_strobe, owner_active, req_uart, req_par;
    logic [31:0] owner_data;

    assign pop          = !fifo_empty && CfgReady;
    assign owner_strobe = ((state_q == ST_GRANT_UART) && UartWriteStrobe) ||
                          ((state_q == ST_GRANT_PAR)  && ParWriteStrobe);
    assign owner_active = (state_q == ST_GRANT_PAR) ? ParActive : UartActive;
    assign owner_data   = (state_q == ST_GRANT_PAR) ? ParWriteData : UartWriteData;
    assign push         = owner_strobe && (!fifo_full || pop);
    assign req_uart     = UartActive && !mask_uart_q;
    assign req_par      = ParActive && !mask_par_q;
    assign fifo_count_next = fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    config_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (CLK),
        .rst       (reset),
        .push      (push),
        .push_data (owner_data),
        .pop       (pop),
        .head_data (CfgWriteData),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        overflow_d  = overflow_q;
        timed_out_d = timed_out_q;
        rejected_d  = 1'b0;
        // A mask only lets go once its loader has withdrawn its request.
        mask_uart_d = mask_uart_q && UartActive;
        mask_par_d  = mask_par_q && ParActive;

        case (state_q)
            ST_IDLE: begin
                if (req_uart || req_par) begin
                    if (req_uart && (!req_par || PRIO_PAR == 0)) begin
                        state_d = ST_GRANT_UART;
                        owner_d = OWNER_UART;
                    end else begin
                        state_d = ST_GRANT_PAR;
                        owner_d = OWNER_PAR;
                    end
                    cnt_d       = TIMEOUT_LOAD;
                    overflow_d  = 1'b0;
                    timed_out_d = 1'b0;
                end
            end
            ST_GRANT_UART, ST_GRANT_PAR: begin
                rejected_d = (state_q == ST_GRANT_UART) ? ParWriteStrobe : UartWriteStrobe;
                if (owner_strobe) begin
                    cnt_d = TIMEOUT_LOAD;
                    if (!push) begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (!owner_active) begin
                    state_d = ST_DRAIN;
                end else if (!owner_strobe && (cnt_q <= CW'(1))) begin
                    state_d     = ST_DRAIN;
                    timed_out_d = 1'b1;
                    if (state_q == ST_GRANT_UART) begin
                        mask_uart_d = 1'b1;
                    end else begin
                        mask_par_d = 1'b1;
                    end
                end
            end
            default: begin
                rejected_d = UartWriteStrobe || ParWriteStrobe;
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    owner_d = OWNER_NONE;
                end
            end
        endcase

        // Pulse in the first DRAIN cycle that sees an empty FIFO.
        session_done_d = (state_d == ST_DRAIN) && (fifo_count_next == '0);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWNER_NONE;
            cnt_q          <= '0;
            mask_uart_q    <= 1'b0;
            mask_par_q     <= 1'b0;
            overflow_q     <= 1'b0;
            timed_out_q    <= 1'b0;
            rejected_q     <= 1'b0;
            session_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            mask_uart_q    <= mask_uart_d;
            mask_par_q     <= mask_par_d;
            overflow_q     <= overflow_d;
            timed_out_q    <= timed_out_d;
            rejected_q     <= rejected_d;
            session_done_q <= session_done_d;
        end
    end

    assign CfgValid    = !fifo_empty;
    assign Owner       = owner_q;
    assign Overflow    = overflow_q;
    assign Rejected    = rejected_q;
    assign TimedOut    = timed_out_q;
    assign SessionDone = session_done_q;

endmodule
